// File: rtl/z_event_logger.sv
// z_event_logger
// Tracks detection episodes from an upstream sequence-detector flag Z.
// It counts episodes, measures the length of the current or latest
// episode, and drives a stretched LED indicator that stays lit for
// STRETCH cycles after Z falls.
// Optional feature: define ZLOG_MAXRUN_EN to add the MaxRun output,
// which holds the longest episode length seen since Reset or Clear.
module z_event_logger #(
    parameter int STRETCH = 4,
    parameter int CW      = 8
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Z,
    input  logic          Clear,
    output logic [CW-1:0] Count,
    output logic [CW-1:0] RunLen,
`ifdef ZLOG_MAXRUN_EN
    output logic [CW-1:0] MaxRun,
`endif
    output logic          Led
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DETECT = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_MAX    = '1;
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [7:0]    STRETCH_M1 = 8'(STRETCH - 1);

    state_t        state_q, state_d;
    logic [7:0]    timer_q, timer_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] runLen_q, runLen_d;
    logic          led_q, led_d;
    logic          incCount;
    logic          loadRun;
    logic          incRun;

    // Next-state decode: FSM transitions, hold timer and counter updates, with Clear overriding counters only
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        count_d  = count_q;
        runLen_d = runLen_q;
        incCount = 1'b0;
        loadRun  = 1'b0;
        incRun   = 1'b0;

        case (state_q)
            IDLE: begin
                if (Z) begin
                    state_d  = DETECT;
                    incCount = 1'b1;
                    loadRun  = 1'b1;
                end
            end
            DETECT: begin
                if (Z) begin
                    incRun = 1'b1;
                end else begin
                    state_d = HOLD;
                    timer_d = STRETCH_M1;
                end
            end
            HOLD: begin
                if (Z) begin
                    state_d  = DETECT;
                    incCount = 1'b1;
                    loadRun  = 1'b1;
                end else if (timer_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = 8'd0;
            end
        endcase

        if (Clear) begin
            count_d  = '0;
            runLen_d = '0;
        end else begin
            if (incCount && (count_q != CNT_MAX)) begin
                count_d = count_q + CNT_ONE;
            end
            if (loadRun) begin
                runLen_d = CNT_ONE;
            end else if (incRun && (runLen_q != CNT_MAX)) begin
                runLen_d = runLen_q + CNT_ONE;
            end
        end

        led_d = (state_d != IDLE);
    end

    // State register: Reset wins over everything and leaves no residual stretch
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            timer_q  <= 8'd0;
            count_q  <= '0;
            runLen_q <= '0;
            led_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            count_q  <= count_d;
            runLen_q <= runLen_d;
            led_q    <= led_d;
        end
    end

    assign Count  = count_q;
    assign RunLen = runLen_q;
    assign Led    = led_q;

`ifdef ZLOG_MAXRUN_EN
    logic [CW-1:0] maxRun_q, maxRun_d;

    // Longest-episode tracker: compares against the RunLen value being written this edge
    always_comb begin
        maxRun_d = maxRun_q;
        if (Clear) begin
            maxRun_d = '0;
        end else if ((loadRun || incRun) && (runLen_d > maxRun_q)) begin
            maxRun_d = runLen_d;
        end
    end

    // Longest-episode register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            maxRun_q <= '0;
        end else begin
            maxRun_q <= maxRun_d;
        end
    end

    assign MaxRun = maxRun_q;
`endif

endmodule

// File: tb/tb_z_event_logger.sv
// Testbench for z_event_logger (STRETCH=4, CW=8).
// Expected outputs are queued as each step is driven and popped for
// comparison one time unit after the following rising edge.
// MaxRun is checked only when built with ZLOG_MAXRUN_EN.
module tb_z_event_logger;

   localparam int CW      = 8;
   localparam int STRETCH = 4;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          Z;
   logic          Clear;
   logic [CW-1:0] Count;
   logic [CW-1:0] RunLen;
`ifdef ZLOG_MAXRUN_EN
   logic [CW-1:0] MaxRun;
`endif
   logic          Led;

   typedef struct {
      string tag;
      int    count;
      int    runLen;
      int    maxRun;
      logic  led;
   } expect_t;

   expect_t expQ[$];
   int checks = 0;
   int errors = 0;

   z_event_logger #(
      .STRETCH(STRETCH),
      .CW(CW)
   ) dut (
      .Clock(Clock),
      .Reset(Reset),
      .Z(Z),
      .Clear(Clear),
      .Count(Count),
      .RunLen(RunLen),
`ifdef ZLOG_MAXRUN_EN
      .MaxRun(MaxRun),
`endif
      .Led(Led)
   );

   // Free-running 10-unit clock
   always #5 Clock = ~Clock;

   // Pops the oldest expectation and compares it with the current outputs
   task automatic checkOutput();
      expect_t e;
      if (expQ.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboardEmpty: observed 0 entries, expected at least 1");
         return;
      end
      e = expQ.pop_front();
      checks++;
      assert (Count === CW'(e.count)) else begin
         errors++;
         $error("FAIL %s.count: observed %0d expected %0d", e.tag, Count, e.count);
      end
      checks++;
      assert (RunLen === CW'(e.runLen)) else begin
         errors++;
         $error("FAIL %s.runLen: observed %0d expected %0d", e.tag, RunLen, e.runLen);
      end
      checks++;
      assert (Led === e.led) else begin
         errors++;
         $error("FAIL %s.led: observed %b expected %b", e.tag, Led, e.led);
      end
`ifdef ZLOG_MAXRUN_EN
      checks++;
      assert (MaxRun === CW'(e.maxRun)) else begin
         errors++;
         $error("FAIL %s.maxRun: observed %0d expected %0d", e.tag, MaxRun, e.maxRun);
      end
`endif
   endtask

   // Drives one cycle of inputs, queues what the outputs must be after the edge, then checks
   task automatic applyStimulus(input logic rst, input logic clr, input logic z,
                                input string tag, input int cnt, input int rl,
                                input int mx, input logic led);
      expect_t e;
      e.tag    = tag;
      e.count  = cnt;
      e.runLen = rl;
      e.maxRun = mx;
      e.led    = led;
      Reset = rst;
      Clear = clr;
      Z     = z;
      expQ.push_back(e);
      @(posedge Clock);
      #1;
      checkOutput();
   endtask

   // Directed sequence
   initial begin
      Reset = 1'b1;
      Clear = 1'b0;
      Z     = 1'b0;
      #1;

      $display("[TB] reset and idle");
      for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, "reset", 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, "idle", 0, 0, 0, 0);

      $display("[TB] single episode with stretch");
      applyStimulus(0, 0, 1, "ep1", 1, 1, 1, 1);
      applyStimulus(0, 0, 1, "ep1", 1, 2, 2, 1);
      applyStimulus(0, 0, 1, "ep1", 1, 3, 3, 1);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, "ep1Stretch", 1, 3, 3, (i < STRETCH));

      $display("[TB] re-entry during hold");
      applyStimulus(0, 1, 0, "clear1", 0, 0, 0, 0);
      applyStimulus(0, 0, 1, "reentry", 1, 1, 1, 1);
      applyStimulus(0, 0, 1, "reentry", 1, 2, 2, 1);
      applyStimulus(0, 0, 0, "reentryHold", 1, 2, 2, 1);
      applyStimulus(0, 0, 0, "reentryHold", 1, 2, 2, 1);
      applyStimulus(0, 0, 1, "reentryNew", 2, 1, 2, 1);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, "reentryDrain", 2, 1, 2, (i < STRETCH));

      $display("[TB] RunLen saturation");
      applyStimulus(0, 1, 0, "clear2", 0, 0, 0, 0);
      for (int i = 0; i < 300; i++) begin
         int rl;
         rl = (i + 1 > 255) ? 255 : i + 1;
         applyStimulus(0, 0, 1, "runSat", 1, rl, rl, 1);
      end
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, "runSatDrain", 1, 255, 255, (i < STRETCH));

      $display("[TB] clear coinciding with episode start");
      applyStimulus(0, 1, 1, "clearStart", 0, 0, 0, 1);
      applyStimulus(0, 0, 1, "clearStart", 0, 1, 1, 1);
      for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, "clearDrain", 0, 1, 1, (i < STRETCH));
      applyStimulus(0, 0, 1, "laterEp", 1, 1, 1, 1);
      applyStimulus(0, 0, 0, "laterHold", 1, 1, 1, 1);

      $display("[TB] reset during hold and detect");
      applyStimulus(1, 0, 0, "rstHold", 0, 0, 0, 0);
      applyStimulus(0, 0, 0, "rstNoStretch", 0, 0, 0, 0);
      applyStimulus(1, 1, 1, "rstPriority", 0, 0, 0, 0);
      applyStimulus(0, 0, 1, "firstAfterRst", 1, 1, 1, 1);
      applyStimulus(1, 0, 1, "rstDetect", 0, 0, 0, 0);

      $display("[TB] Count saturation via hold re-entry");
      for (int k = 1; k <= 260; k++) begin
         int c;
         c = (k > 255) ? 255 : k;
         applyStimulus(0, 0, 1, "cntSat", c, 1, 1, 1);
         applyStimulus(0, 0, 0, "cntSatHold", c, 1, 1, 1);
      end

      $display("[TB] clear during hold keeps the stretch");
      applyStimulus(0, 1, 0, "clearHold", 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, "clearHoldDrain", 0, 0, 0, (i < 2));

      checks++;
      assert (expQ.size() == 0) else begin
         errors++;
         $error("FAIL scoreboardLeftover: observed %0d entries, expected 0", expQ.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
